// File: rtl/feature_unloader_pkg.sv
// -----------------------------------------------------------------------------
// feature_unloader_pkg
// Shared accelerator definitions for the feature unloader:
//   - fu_state_e : unloader FSM states (IDLE / SEND / DONE)
//   - fu_epb     : elements carried by one output beat
//   - fu_beats   : number of beats needed to carry a given element count
// -----------------------------------------------------------------------------
package feature_unloader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } fu_state_e;

    // Elements per output beat.
    function automatic int fu_epb(input int output_width, input int element_width);
        return output_width / element_width;
    endfunction

    // Beats needed for len elements, rounded up to whole beats.
    function automatic int fu_beats(input int len, input int epb);
        return (len + epb - 32'sd1) / epb;
    endfunction

endpackage

// File: rtl/feature_unloader.sv
// -----------------------------------------------------------------------------
// feature_unloader
// Snapshots a parallel element vector on capture_i and streams it out as a
// sequence of wide beats with a valid/ready handshake.
//
// Ports:
//   clk        in   clock, all state changes on rising edge
//   nrst       in   asynchronous reset, active high
//   data_i     in   numElements x elementWidth parallel element vector
//   capture_i  in   snapshot data_i and start unloading (ignored while busy)
//   len_i      in   number of elements to send, 0 means numElements
//   ready_i    in   downstream accepts the current beat
//   data_o     out  current beat, element k at [k*elementWidth +: elementWidth]
//   addr_o     out  element index of element 0 of the current beat
//   valid_o    out  current beat is valid
//   last_o     out  current beat is the final one
//   busy_o     out  transfer in progress (SEND or DONE)
//   done_o     out  one-cycle pulse after the final handshake
// All outputs are registered.
// -----------------------------------------------------------------------------
module feature_unloader
    import feature_unloader_pkg::*;
#(
    parameter int outputWidth  = 256,
    parameter int addrWidth    = 8,
    parameter int elementWidth = 8,
    parameter int numElements  = 128
) (
    input  logic                                clk,
    input  logic                                nrst,
    input  logic [numElements*elementWidth-1:0] data_i,
    input  logic                                capture_i,
    input  logic [addrWidth-1:0]                len_i,
    input  logic                                ready_i,
    output logic [outputWidth-1:0]              data_o,
    output logic [addrWidth-1:0]                addr_o,
    output logic                                valid_o,
    output logic                                last_o,
    output logic                                busy_o,
    output logic                                done_o
);

    localparam int EPB   = fu_epb(outputWidth, elementWidth);
    localparam int VEC_W = numElements * elementWidth;
    // One extra bit so that a full-vector length always fits.
    localparam int LEN_W = addrWidth + 1;

    generate
        if ((numElements % EPB) != 0) begin : g_bad_cfg
            $error("feature_unloader: numElements must be a multiple of elements per beat");
        end
    endgenerate

    fu_state_e              r_state;
    logic [VEC_W-1:0]       r_snap;
    logic [LEN_W-1:0]       r_len;
    logic [addrWidth-1:0]   r_ptr;
    logic [addrWidth-1:0]   r_last_ptr;
    logic [outputWidth-1:0] r_data;
    logic [addrWidth-1:0]   r_addr;
    logic                   r_valid;
    logic                   r_last;
    logic                   r_busy;
    logic                   r_done;

    int                     w_eff_len;
    int                     w_len_sel;
    int                     w_ptr_sel;
    int                     w_last_sel;
    logic [VEC_W-1:0]       w_src;
    logic [outputWidth-1:0] w_beat;
    logic                   w_is_last;
    logic                   w_handshake;

    assign data_o  = r_data;
    assign addr_o  = r_addr;
    assign valid_o = r_valid;
    assign last_o  = r_last;
    assign busy_o  = r_busy;
    assign done_o  = r_done;

    assign w_handshake = r_valid & ready_i;
    assign w_is_last   = (w_ptr_sel == w_last_sel);

    // Effective length: zero selects the whole vector; oversize lengths are
    // clamped so the address can never run past the vector.
    always_comb begin
        if (len_i == {addrWidth{1'b0}}) begin
            w_eff_len = numElements;
        end else if (int'(len_i) > numElements) begin
            w_eff_len = numElements;
        end else begin
            w_eff_len = int'(len_i);
        end
    end

    // Operands of the next beat to load: in IDLE it is beat 0 taken straight
    // from data_i (so the first beat is ready one cycle after capture);
    // otherwise it is the following beat out of the snapshot.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_src      = data_i;
            w_len_sel  = w_eff_len;
            w_ptr_sel  = 32'sd0;
            w_last_sel = fu_beats(w_eff_len, EPB) - 32'sd1;
        end else begin
            w_src      = r_snap;
            w_len_sel  = int'(r_len);
            w_ptr_sel  = int'(r_ptr) + 32'sd1;
            w_last_sel = int'(r_last_ptr);
        end
    end

    // Assemble the next beat; elements at or beyond the length read as zero.
    always_comb begin
        w_beat = {outputWidth{1'b0}};
        for (int k = 0; k < EPB; k++) begin
            if ((w_ptr_sel * EPB + k) < w_len_sel) begin
                w_beat[k*elementWidth +: elementWidth] =
                    w_src[(w_ptr_sel * EPB + k)*elementWidth +: elementWidth];
            end else begin
                w_beat[k*elementWidth +: elementWidth] = {elementWidth{1'b0}};
            end
        end
    end

    // Unloader FSM with snapshot, pointer and registered outputs.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_state    <= ST_IDLE;
            r_snap     <= {VEC_W{1'b0}};
            r_len      <= {LEN_W{1'b0}};
            r_ptr      <= {addrWidth{1'b0}};
            r_last_ptr <= {addrWidth{1'b0}};
            r_data     <= {outputWidth{1'b0}};
            r_addr     <= {addrWidth{1'b0}};
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (capture_i) begin
                        r_state    <= ST_SEND;
                        r_snap     <= data_i;
                        r_len      <= LEN_W'(w_eff_len);
                        r_ptr      <= {addrWidth{1'b0}};
                        r_last_ptr <= addrWidth'(w_last_sel);
                        r_data     <= w_beat;
                        r_addr     <= addrWidth'(w_ptr_sel * EPB);
                        r_valid    <= 1'b1;
                        r_last     <= w_is_last;
                        r_busy     <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (w_handshake) begin
                        if (r_last) begin
                            r_state <= ST_DONE;
                            r_data  <= {outputWidth{1'b0}};
                            r_addr  <= {addrWidth{1'b0}};
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_ptr  <= addrWidth'(w_ptr_sel);
                            r_data <= w_beat;
                            r_addr <= addrWidth'(w_ptr_sel * EPB);
                            r_last <= w_is_last;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_data  <= {outputWidth{1'b0}};
                    r_addr  <= {addrWidth{1'b0}};
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
